// File: rtl/riscv_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Holds the arbiter FSM states and the response-owner record.
package riscv_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // One entry per granted access, consumed on the following cycle.
    typedef struct packed {
        logic valid;
        logic port;
        logic we;
    } resp_own_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin pick: on contention the port that did not win last time wins.
// pick[0] selects port 0, pick[1] selects port 1; at most one bit is set.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (req0 && req1) begin
            pick = last ? 2'b01 : 2'b10;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin, atomic lock ownership and a hold timeout.
// Grants are combinational; responses return one cycle later through a single owner register.
//
// Handshake: a port holds reqN with its fields stable until it sees gntN high in the same
// cycle; fields are taken only in that cycle, and rvalidN follows exactly one cycle later.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0,
    input  logic            we0,
    input  logic [AW-1:0]   addr0,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW/8-1:0] mask0,
    input  logic            lock0,

    input  logic            req1,
    input  logic            we1,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW/8-1:0] mask1,
    input  logic            lock1,

    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata,
    output logic            stall0,

    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_mask,
    input  logic [DW-1:0]   mem_rdata,

    output arb_state_e      dbg_state
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_e  state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        last_q, last_d;
    resp_own_t   resp_q, resp_d;
    logic        post_rst_q, post_rst_d;

    logic        block;
    logic        own_expired;
    logic        arbitrating;
    logic        arb_last;
    logic        other_req;
    logic [1:0]  pick;
    logic [HW-1:0] hold_inc;

    // Grants are suppressed while reset is high and for one cycle after it.
    assign post_rst_d = rst;
    assign block      = rst | post_rst_q;

    assign other_req   = (state_q == OWN0) ? req1 : req0;
    assign own_expired = (state_q != IDLE) && (hold_q == HW'(MAX_HOLD)) && other_req;
    assign arbitrating = (state_q == IDLE) || own_expired;
    // An expired owner counts as the last winner so the waiting port is favoured.
    assign arb_last    = own_expired ? (state_q == OWN1) : last_q;
    assign hold_inc    = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (arb_last),
        .pick (pick)
    );

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!block) begin
            if (arbitrating) begin
                gnt0 = pick[0];
                gnt1 = pick[1];
            end else if (state_q == OWN0) begin
                gnt0 = req0;
            end else begin
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_mask  = mask0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_mask  = mask1;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        resp_d  = '{valid: mem_en, port: gnt1, we: mem_we};

        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end

        if (arbitrating) begin
            if (gnt0 && lock0) begin
                state_d = OWN0;
                hold_d  = HW'(1);
            end else if (gnt1 && lock1) begin
                state_d = OWN1;
                hold_d  = HW'(1);
            end else begin
                state_d = IDLE;
                hold_d  = '0;
            end
        end else if ((state_q == OWN0 && gnt0 && !lock0) ||
                     (state_q != OWN0 && gnt1 && !lock1)) begin
            state_d = IDLE;
            hold_d  = '0;
        end else if (gnt0 || gnt1) begin
            // Release on the grant that exhausts the budget if the other port is waiting.
            if (hold_inc == HW'(MAX_HOLD) && other_req) begin
                state_d = IDLE;
                hold_d  = '0;
            end else begin
                hold_d = hold_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        post_rst_q <= post_rst_d;
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            resp_q  <= resp_d;
        end
    end

    assign rvalid0   = resp_q.valid & ~resp_q.port & ~rst;
    assign rvalid1   = resp_q.valid &  resp_q.port & ~rst;
    assign rdata     = (resp_q.valid & ~resp_q.we & ~rst) ? mem_rdata : '0;
    assign stall0    = req0 & ~gnt0 & ~block;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: read path, round-robin, lock, lock timeout,
// masked store/load and reset behaviour, against a small synchronous memory model.
module tb_dmem_arbiter;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  mask0, mask1;
    logic        gnt0, gnt1, rvalid0, rvalid1, stall0;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    arb_state_e  dbg_state;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .mask0     (mask0),
        .lock0     (lock0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .mask1     (mask1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .stall0    (stall0),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: masked writes, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_mask[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_p0(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m, input logic l);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; mask0 = m; lock0 = l;
    endtask

    task automatic set_p1(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m, input logic l);
        req1 = r; we1 = w; addr1 = a; wdata1 = d; mask1 = m; lock1 = l;
    endtask

    // Inputs are applied on the falling edge; outputs are sampled 1 time unit later.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]    = 32'hDEADBEEF;
        mem[8]    = 32'hAABBCCDD;
        mem_rdata = 32'h0;
        rst = 1'b1;
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Reset: outputs quiet even with a request present.
        @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        #1;
        check("rst_gnt0",    32'(gnt0),    32'd0);
        check("rst_stall0",  32'(stall0),  32'd0);
        check("rst_mem_en",  32'(mem_en),  32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rdata",   rdata,        32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_gnt0",   32'(gnt0),      32'd0);
        check("post_rst_stall0", 32'(stall0),    32'd0);
        check("post_rst_state",  32'(dbg_state), 32'(IDLE));

        // Single read of 0x10.
        @(negedge clk);
        #1;
        check("rd_gnt0",     32'(gnt0),   32'd1);
        check("rd_stall0",   32'(stall0), 32'd0);
        check("rd_mem_en",   32'(mem_en), 32'd1);
        check("rd_mem_we",   32'(mem_we), 32'd0);
        check("rd_mem_addr", mem_addr,    32'h10);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("rd_rvalid0",    32'(rvalid0), 32'd1);
        check("rd_rdata",      rdata,        32'hDEADBEEF);
        check("rd_idle_en",    32'(mem_en),  32'd0);
        check("rd_idle_addr",  mem_addr,     32'h0);

        // Round-robin after reset: 0,1,0,1.
        do_reset();
        @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        set_p1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
        #1;
        check("rr1_gnt0", 32'(gnt0), 32'd1);
        check("rr1_gnt1", 32'(gnt1), 32'd0);
        check("rr1_stall0", 32'(stall0), 32'd0);
        @(negedge clk);
        #1;
        check("rr2_gnt1", 32'(gnt1), 32'd1);
        check("rr2_gnt0", 32'(gnt0), 32'd0);
        check("rr2_stall0", 32'(stall0), 32'd1);
        check("rr2_mem_addr", mem_addr, 32'h24);
        check("rr2_rvalid0", 32'(rvalid0), 32'd1);
        @(negedge clk);
        #1;
        check("rr3_gnt0", 32'(gnt0), 32'd1);
        check("rr3_stall0", 32'(stall0), 32'd0);
        check("rr3_rvalid1", 32'(rvalid1), 32'd1);
        @(negedge clk);
        #1;
        check("rr4_gnt1", 32'(gnt1), 32'd1);
        check("rr4_stall0", 32'(stall0), 32'd1);

        // One solo port-0 grant so port 1 wins the next contention.
        @(negedge clk);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("solo_gnt0", 32'(gnt0), 32'd1);

        // Port 1 locked for three writes, releases on the fourth.
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            set_p1(1'b1, 1'b1, 32'h30 + 32'(c * 4), 32'(c), 4'hF, (c <= 3));
            #1;
            check("lock_gnt1",   32'(gnt1),   32'd1);
            check("lock_stall0", 32'(stall0), 32'd1);
            if (c == 2) check("lock_state", 32'(dbg_state), 32'(OWN1));
        end
        @(negedge clk);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("unlock_gnt0",  32'(gnt0),      32'd1);
        check("unlock_state", 32'(dbg_state), 32'(IDLE));

        // Lock stuck high: timeout after eight port-1 grants.
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            set_p1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1);
            #1;
            check("hold_gnt1",   32'(gnt1),   32'd1);
            check("hold_stall0", 32'(stall0), 32'd1);
        end
        @(negedge clk);
        #1;
        check("timeout_gnt0",  32'(gnt0),      32'd1);
        check("timeout_gnt1",  32'(gnt1),      32'd0);
        check("timeout_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("timeout_rvalid0", 32'(rvalid0), 32'd1);

        // Masked store then load of 0x20, back to back.
        @(negedge clk);
        set_p0(1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011, 1'b0);
        #1;
        check("st_gnt0",      32'(gnt0),   32'd1);
        check("st_mem_we",    32'(mem_we), 32'd1);
        check("st_mem_mask",  32'(mem_mask), 32'h3);
        check("st_mem_wdata", mem_wdata,   32'h12345678);
        @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        #1;
        check("ld_gnt0",    32'(gnt0),    32'd1);
        check("st_rvalid0", 32'(rvalid0), 32'd1);
        check("st_rdata",   rdata,        32'h0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("ld_rvalid0", 32'(rvalid0), 32'd1);
        check("ld_rdata",   rdata,        32'hAABB5678);

        // Reset in the cycle after a grant swallows its response.
        @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        #1;
        check("pre_rst_gnt0", 32'(gnt0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid0", 32'(rvalid0), 32'd0);
        check("mid_rst_gnt0",    32'(gnt0),    32'd0);
        check("mid_rst_rdata",   rdata,        32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_p1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
        #1;
        check("after_rst_rvalid0", 32'(rvalid0), 32'd0);
        check("after_rst_gnt0",    32'(gnt0),     32'd0);
        check("after_rst_gnt1",    32'(gnt1),     32'd0);
        check("after_rst_mem_en",  32'(mem_en),   32'd0);
        check("after_rst_state",   32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        #1;
        check("first_win_gnt0",   32'(gnt0),    32'd1);
        check("first_win_gnt1",   32'(gnt1),    32'd0);
        check("first_win_rvalid", 32'(rvalid0), 32'd0);
        @(negedge clk);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("first_win_rdata", rdata, 32'hDEADBEEF);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
